// File: rtl/imm_pack_if.sv
// Request/response stream bundle for imm_pack: immediate-pack requests in,
// packed instruction words with byte addresses out.
interface imm_pack_if #(
  parameter int ADDR_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_imm_src;
  logic [31:0]       in_base;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_imm_src, in_base, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_imm_src, in_base, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/imm_pack.sv
// Immediate packer: range-checks a signed immediate, scatters it into the
// class-specific fields of a base instruction and queues it with a byte address.
module imm_pack #(
  parameter int                DEPTH      = 4,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  imm_pack_if.slave         bus,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_load_val,
  input  logic              flush,
  output logic              range_err,
  output logic [7:0]        err_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [ADDR_W-1:0] wr_addr_reg, wr_addr_next;
  logic              ready_en_reg;
  logic              range_err_reg;
  logic [7:0]        err_count_reg;

  logic              accept, legal, push, pop, reject;
  logic [11:0]       imm_v;
  logic [31:0]       pack_word;

  // in_ready is held low during reset and for the edge that releases it
  assign bus.in_ready = ready_en_reg && (count_reg != CNT_W'(DEPTH)) && !flush;
  assign accept       = bus.in_valid && bus.in_ready;
  assign legal        = (&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]);
  assign push         = accept && legal;
  assign reject       = accept && !legal;
  assign pop          = bus.out_valid && bus.out_ready && !flush;

  assign imm_v = bus.in_imm[11:0];

  always_comb begin
    pack_word = bus.in_base;
    case (bus.in_imm_src)
      2'b00: pack_word[31:20] = imm_v[11:0];
      2'b01: begin
        pack_word[31:25] = imm_v[11:5];
        pack_word[11:7]  = imm_v[4:0];
      end
      2'b10: begin
        pack_word[31]    = imm_v[11];
        pack_word[7]     = imm_v[10];
        pack_word[30:25] = imm_v[9:4];
        pack_word[11:8]  = imm_v[3:0];
      end
      default: begin
        pack_word[12]    = imm_v[11];
        pack_word[20]    = imm_v[10];
        pack_word[30:21] = imm_v[9:0];
      end
    endcase
  end

  // addr_load wins over the post-enqueue increment; the enqueued word keeps the old tag
  always_comb begin
    wr_addr_next = wr_addr_reg;
    if (addr_load)
      wr_addr_next = addr_load_val & ~ADDR_W'(3);
    else if (push)
      wr_addr_next = wr_addr_reg + ADDR_W'(4);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= pack_word;
      addr_mem[wr_ptr_reg]  <= wr_addr_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      wr_addr_reg   <= RESET_ADDR;
      ready_en_reg  <= 1'b0;
      range_err_reg <= 1'b0;
      err_count_reg <= '0;
    end else begin
      ready_en_reg  <= 1'b1;
      wr_addr_reg   <= wr_addr_next;
      range_err_reg <= reject;
      if (reject && (err_count_reg != 8'hFF))
        err_count_reg <= err_count_reg + 8'd1;

      if (flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push)
          wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)
          rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        if (push && !pop)
          count_reg <= count_reg + CNT_W'(1);
        else if (pop && !push)
          count_reg <= count_reg - CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = (count_reg != '0);
  assign bus.out_instr = bus.out_valid ? instr_mem[rd_ptr_reg] : '0;
  assign bus.out_addr  = bus.out_valid ? addr_mem[rd_ptr_reg]  : '0;
  assign range_err     = range_err_reg;
  assign err_count     = err_count_reg;

endmodule
